// File: rtl/bch_share_arbiter_if.sv
// Handshake bundle around the shared BCH decoder arbiter: two coded input streams,
// two corrected output streams, the decoder's ports and the status outputs.
interface bch_share_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             s0_valid;
  logic             s0_data;
  logic             s0_ready;
  logic             s1_valid;
  logic             s1_data;
  logic             s1_ready;
  logic             m0_valid;
  logic             m0_data;
  logic             m0_last;
  logic             m0_ready;
  logic             m1_valid;
  logic             m1_data;
  logic             m1_last;
  logic             m1_ready;
  logic             dec_in_valid;
  logic             dec_in_data;
  logic             dec_in_ready;
  logic             dec_out_valid;
  logic             dec_out_data;
  logic             dec_out_ready;
  logic             grant;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt0;
  logic [CNT_W-1:0] frame_cnt1;

  // Arbiter side
  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, m0_ready, m1_ready,
           dec_in_ready, dec_out_valid, dec_out_data,
    output s0_ready, s1_ready, m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last,
           dec_in_valid, dec_in_data, dec_out_ready, grant, busy, frame_cnt0, frame_cnt1
  );

  // Requesters, sinks and decoder side
  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, m0_ready, m1_ready,
           dec_in_ready, dec_out_valid, dec_out_data,
    input  s0_ready, s1_ready, m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last,
           dec_in_valid, dec_in_data, dec_out_ready, grant, busy, frame_cnt0, frame_cnt1
  );
endinterface

// File: rtl/bch_share_arbiter.sv
// Shares one BCH decoder between two bit-serial channels; a channel owns the decoder
// for a whole frame (feed then drain), ties are broken round robin.
module bch_share_arbiter #(
  parameter int FRAME_LEN = 63,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  bch_share_arbiter_if.slave bus
);
  localparam int BEAT_W = $clog2(FRAME_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_grant;
  logic              r_last_grant;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic w_any_req;
  logic w_pick;
  logic w_beat_end;
  logic w_in_xfer;
  logic w_out_xfer;

  assign w_any_req  = bus.s0_valid || bus.s1_valid;
  assign w_pick     = (bus.s0_valid && bus.s1_valid) ? ~r_last_grant : bus.s1_valid;
  assign w_beat_end = (r_beat == LAST_BEAT);
  assign w_in_xfer  = bus.dec_in_valid && bus.dec_in_ready;
  assign w_out_xfer = bus.dec_out_valid && bus.dec_out_ready;

  assign bus.grant      = r_grant;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.frame_cnt0 = r_cnt0;
  assign bus.frame_cnt1 = r_cnt1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any_req)                w_next_state = ST_FEED;
      ST_FEED:  if (w_in_xfer && w_beat_end)  w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_out_xfer && w_beat_end) w_next_state = ST_IDLE;
      default:                                w_next_state = ST_IDLE;
    endcase
  end

  // One beat counter serves both phases; it is back at zero whenever a phase ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat       <= '0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_any_req) r_grant <= w_pick;
        ST_FEED: if (w_in_xfer) r_beat <= w_beat_end ? '0 : r_beat + 1'b1;
        ST_DRAIN: if (w_out_xfer) begin
          if (w_beat_end) begin
            r_beat       <= '0;
            r_last_grant <= r_grant;
            if (r_grant) r_cnt1 <= r_cnt1 + 1'b1;
            else         r_cnt0 <= r_cnt0 + 1'b1;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.s0_ready      = 1'b0;
    bus.s1_ready      = 1'b0;
    bus.m0_valid      = 1'b0;
    bus.m0_data       = 1'b0;
    bus.m0_last       = 1'b0;
    bus.m1_valid      = 1'b0;
    bus.m1_data       = 1'b0;
    bus.m1_last       = 1'b0;
    bus.dec_in_valid  = 1'b0;
    bus.dec_in_data   = 1'b0;
    bus.dec_out_ready = 1'b0;
    unique case (r_state)
      ST_FEED: begin
        if (r_grant) begin
          bus.dec_in_valid = bus.s1_valid;
          bus.dec_in_data  = bus.s1_data;
          bus.s1_ready     = bus.dec_in_ready;
        end else begin
          bus.dec_in_valid = bus.s0_valid;
          bus.dec_in_data  = bus.s0_data;
          bus.s0_ready     = bus.dec_in_ready;
        end
      end
      ST_DRAIN: begin
        if (r_grant) begin
          bus.m1_valid      = bus.dec_out_valid;
          bus.m1_data       = bus.dec_out_data;
          bus.m1_last       = bus.dec_out_valid && w_beat_end;
          bus.dec_out_ready = bus.m1_ready;
        end else begin
          bus.m0_valid      = bus.dec_out_valid;
          bus.m0_data       = bus.dec_out_data;
          bus.m0_last       = bus.dec_out_valid && w_beat_end;
          bus.dec_out_ready = bus.m0_ready;
        end
      end
      default: ;
    endcase
  end
endmodule
